// File: rtl/inst_queue.sv
// Circular instruction FIFO between fetch and decode. The head {inst, pc} pair
// is presented combinationally so decode can consume it in the same cycle.
module inst_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              we_if_i,
  input  logic [31:0]       inst_if_i,
  input  logic [31:0]       pc_if_i,
  output logic              full_if_o,
  input  logic              re_id_i,
  output logic [31:0]       inst_id_o,
  output logic [31:0]       pc_id_o,
  output logic              empty_id_o,
  output logic [ADDR_W:0]   count_o
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  logic [63:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              push, pop, wr_en;
  logic [63:0]       head_entry;

  assign empty_id_o = (count_q == '0);
  assign full_if_o  = (count_q == DEPTH_CNT);
  assign count_o    = count_q;
  assign head_entry = mem_q[head_q];
  assign inst_id_o  = empty_id_o ? 32'b0 : head_entry[63:32];
  assign pc_id_o    = empty_id_o ? 32'b0 : head_entry[31:0];

  // Qualification uses the pre-edge occupancy: a full queue drops the write
  // even when a pop frees a slot in the same cycle, and an empty queue ignores
  // a pop even when a write arrives (no bypass).
  always_comb begin
    push    = we_if_i && !full_if_o;
    pop     = re_id_i && !empty_id_o;
    wr_en   = 1'b0;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      wr_en = push;
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[tail_q] <= {inst_if_i, pc_if_i};
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue: ordering, wrap, simultaneous
// push/pop at the empty and full boundaries, and pipeline clear.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_i = 1'b0;
  logic        we_if_i = 1'b0;
  logic [31:0] inst_if_i = '0;
  logic [31:0] pc_if_i = '0;
  logic        full_if_o;
  logic        re_id_i = 1'b0;
  logic [31:0] inst_id_o;
  logic [31:0] pc_id_o;
  logic        empty_id_o;
  logic [4:0]  count_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear_i),
    .we_if_i    (we_if_i),
    .inst_if_i  (inst_if_i),
    .pc_if_i    (pc_if_i),
    .full_if_o  (full_if_o),
    .re_id_i    (re_id_i),
    .inst_id_o  (inst_id_o),
    .pc_id_o    (pc_id_o),
    .empty_id_o (empty_id_o),
    .count_o    (count_o)
  );

  // Drives one cycle of stimulus, then returns 1 ns after the edge with
  // inputs idle so outputs can be sampled away from the edge.
  task automatic cyc(input logic we, input logic [31:0] inst, input logic [31:0] pc,
                     input logic re, input logic clr);
    we_if_i   = we;
    inst_if_i = inst;
    pc_if_i   = pc;
    re_id_i   = re;
    clear_i   = clr;
    @(posedge clk);
    #1;
    we_if_i = 1'b0;
    re_id_i = 1'b0;
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    total_cnt++;
    if ({empty_id_o, full_if_o, count_o} !== {1'b1, 1'b0, 5'd0})
      $display("FAIL reset_flags got empty=%0b full=%0b count=%0d exp 1 0 0", empty_id_o, full_if_o, count_o);
    else pass_cnt++;
    total_cnt++;
    if ({inst_id_o, pc_id_o} !== 64'h0)
      $display("FAIL reset_head got %h/%h exp 0/0", inst_id_o, pc_id_o);
    else pass_cnt++;
  endtask

  task automatic test_order();
    cyc(1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0);
    total_cnt++;
    if ({inst_id_o, pc_id_o, count_o} !== {32'h00500093, 32'h0, 5'd1})
      $display("FAIL order_first got %h/%h cnt %0d exp 00500093/0 cnt 1", inst_id_o, pc_id_o, count_o);
    else pass_cnt++;
    cyc(1'b1, 32'h00A00113, 32'h4, 1'b0, 1'b0);
    total_cnt++;
    if ({inst_id_o, count_o} !== {32'h00500093, 5'd2})
      $display("FAIL order_two got %h cnt %0d exp 00500093 cnt 2", inst_id_o, count_o);
    else pass_cnt++;
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    total_cnt++;
    if ({inst_id_o, pc_id_o, count_o} !== {32'h00A00113, 32'h4, 5'd1})
      $display("FAIL order_pop1 got %h/%h cnt %0d exp 00a00113/4 cnt 1", inst_id_o, pc_id_o, count_o);
    else pass_cnt++;
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    total_cnt++;
    if ({empty_id_o, inst_id_o, pc_id_o} !== {1'b1, 64'h0})
      $display("FAIL order_empty got empty=%0b %h/%h exp 1 0/0", empty_id_o, inst_id_o, pc_id_o);
    else pass_cnt++;
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'h1000 + i, 32'(i * 4), 1'b0, 1'b0);
    total_cnt++;
    if ({full_if_o, count_o} !== {1'b1, 5'd16})
      $display("FAIL fill_full got full=%0b cnt %0d exp 1 16", full_if_o, count_o);
    else pass_cnt++;
    cyc(1'b1, 32'hDEAD, 32'h999, 1'b0, 1'b0);
    total_cnt++;
    if ({count_o, pc_id_o} !== {5'd16, 32'h0})
      $display("FAIL fill_17th got cnt %0d pc %h exp 16 0", count_o, pc_id_o);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    total_cnt++;
    if ({count_o, pc_id_o} !== {5'd12, 32'h10})
      $display("FAIL fill_pop4 got cnt %0d pc %h exp 12 10", count_o, pc_id_o);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h2000 + i, 32'h40 + 32'(i * 4), 1'b0, 1'b0);
    total_cnt++;
    if ({full_if_o, count_o} !== {1'b1, 5'd16})
      $display("FAIL wrap_full got full=%0b cnt %0d exp 1 16", full_if_o, count_o);
    else pass_cnt++;
    for (int k = 0; k < 16; k++) begin
      total_cnt++;
      if (pc_id_o !== 32'h10 + 32'(k * 4))
        $display("FAIL wrap_order[%0d] got pc %h exp %h", k, pc_id_o, 32'h10 + 32'(k * 4));
      else pass_cnt++;
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    total_cnt++;
    if (empty_id_o !== 1'b1)
      $display("FAIL wrap_drain got empty=%0b exp 1", empty_id_o);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc [5];
    exp_pc[0] = 32'h30C; exp_pc[1] = 32'h310;
    exp_pc[2] = 32'h400; exp_pc[3] = 32'h404; exp_pc[4] = 32'h408;
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h3000 + i, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'h4000 + i, 32'h400 + 32'(i * 4), 1'b1, 1'b0);
      total_cnt++;
      if (count_o !== 5'd5)
        $display("FAIL simul_count[%0d] got %0d exp 5", i, count_o);
      else pass_cnt++;
    end
    for (int k = 0; k < 5; k++) begin
      total_cnt++;
      if (pc_id_o !== exp_pc[k])
        $display("FAIL simul_order[%0d] got pc %h exp %h", k, pc_id_o, exp_pc[k]);
      else pass_cnt++;
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'h5000 + i, 32'h500 + 32'(i * 4), 1'b0, 1'b0);
    cyc(1'b1, 32'hBAD, 32'h999, 1'b1, 1'b0);
    total_cnt++;
    if ({full_if_o, count_o, pc_id_o} !== {1'b0, 5'd15, 32'h504})
      $display("FAIL full_we_re got full=%0b cnt %0d pc %h exp 0 15 504", full_if_o, count_o, pc_id_o);
    else pass_cnt++;
    for (int i = 0; i < 15; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    total_cnt++;
    if ({empty_id_o, count_o} !== {1'b1, 5'd0})
      $display("FAIL full_drop got empty=%0b cnt %0d exp 1 0", empty_id_o, count_o);
    else pass_cnt++;
  endtask

  task automatic test_empty_we_re();
    cyc(1'b1, 32'hABC, 32'h100, 1'b1, 1'b0);
    total_cnt++;
    if ({count_o, inst_id_o, pc_id_o} !== {5'd1, 32'hABC, 32'h100})
      $display("FAIL empty_we_re got cnt %0d %h/%h exp 1 abc/100", count_o, inst_id_o, pc_id_o);
    else pass_cnt++;
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_clear();
    for (int i = 0; i < 9; i++) cyc(1'b1, 32'h6000 + i, 32'h600 + 32'(i * 4), 1'b0, 1'b0);
    total_cnt++;
    if (count_o !== 5'd9)
      $display("FAIL clear_pre got cnt %0d exp 9", count_o);
    else pass_cnt++;
    cyc(1'b1, 32'h777, 32'h777, 1'b0, 1'b1);
    total_cnt++;
    if ({count_o, empty_id_o, inst_id_o, pc_id_o} !== {5'd0, 1'b1, 64'h0})
      $display("FAIL clear_flush got cnt %0d empty=%0b %h/%h exp 0 1 0/0", count_o, empty_id_o, inst_id_o, pc_id_o);
    else pass_cnt++;
    cyc(1'b1, 32'h222, 32'h200, 1'b0, 1'b0);
    total_cnt++;
    if ({count_o, inst_id_o, pc_id_o} !== {5'd1, 32'h222, 32'h200})
      $display("FAIL clear_newhead got cnt %0d %h/%h exp 1 222/200", count_o, inst_id_o, pc_id_o);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_order();
    test_fill_wrap();
    test_back_to_back();
    test_empty_we_re();
    test_clear();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
